// File: rtl/z80_bus_master.sv
// rtl/z80_bus_master.sv - Z80-style bus cycle master with wait states, timeout and bus release
module z80_bus_master #(
  parameter int MAX_WAIT = 255
) (
  input  logic        CLK,
  input  logic        nRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic        cmd_io,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] A,
  output logic [7:0]  D_out,
  output logic        D_oe,
  input  logic [7:0]  D_in,
  output logic        nMREQ,
  output logic        nIORQ,
  output logic        nRD,
  output logic        nWR,
  input  logic        nWAIT,
  input  logic        nBUSRQ,
  output logic        nBUSACK
);

  localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_T1,
    S_T2,
    S_TA,
    S_TW,
    S_T3,
    S_BUSREL
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             err_q, err_d;
  logic             write_q, write_d;
  logic             io_q, io_d;
  logic             alive_q;
  logic [15:0]      addr_q, addr_d;
  logic [7:0]       dout_q, dout_d;
  logic             doe_q, doe_d;
  logic             nmreq_q, nmreq_d;
  logic             niorq_q, niorq_d;
  logic             nrd_q, nrd_d;
  logic             nwr_q, nwr_d;
  logic             nbusack_q, nbusack_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_err_q, rsp_err_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             accept;
  logic             act_d;
  logic             late_d;

  // alive_q keeps cmd_ready low until the first edge after reset release
  assign cmd_ready = alive_q && (state_q == S_IDLE) && nBUSRQ;
  assign accept    = cmd_valid && cmd_ready;

  assign A         = addr_q;
  assign D_out     = dout_q;
  assign D_oe      = doe_q;
  assign nMREQ     = nmreq_q;
  assign nIORQ     = niorq_q;
  assign nRD       = nrd_q;
  assign nWR       = nwr_q;
  assign nBUSACK   = nbusack_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rdata_q;

  // Next-state logic; bus outputs are derived from the next state so they come straight from flops
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    write_d    = write_q;
    io_d       = io_q;

    case (state_q)
      S_IDLE: begin
        if (!nBUSRQ) begin
          state_d = S_BUSREL;
        end else if (accept) begin
          state_d    = S_T1;
          write_d    = cmd_write;
          io_d       = cmd_io;
          err_d      = 1'b0;
          wait_cnt_d = '0;
        end
      end
      S_T1: state_d = S_T2;
      S_T2, S_TA: begin
        if ((state_q == S_T2) && io_q) begin
          state_d = S_TA;
        end else if (nWAIT) begin
          state_d = S_T3;
        end else if (MAX_WAIT == 0) begin
          state_d = S_T3;
          err_d   = 1'b1;
        end else begin
          state_d    = S_TW;
          wait_cnt_d = CNT_W'(1);
        end
      end
      S_TW: begin
        if (wait_cnt_q == CNT_MAX) begin
          state_d = S_T3;
          err_d   = 1'b1;
        end else if (!nWAIT) begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end else begin
          state_d = S_T3;
        end
      end
      S_T3:     state_d = S_IDLE;
      S_BUSREL: if (nBUSRQ) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    act_d  = state_d inside {S_T1, S_T2, S_TA, S_TW, S_T3};
    late_d = state_d inside {S_T2, S_TA, S_TW, S_T3};

    nmreq_d   = !(act_d && !io_d);
    niorq_d   = !(late_d && io_d);
    nrd_d     = !(!write_d && (io_d ? late_d : act_d));
    nwr_d     = !(write_d && late_d);
    doe_d     = write_d && act_d;
    nbusack_d = (state_d != S_BUSREL);

    addr_d = accept ? cmd_addr : addr_q;
    dout_d = accept ? cmd_wdata : dout_q;

    rsp_valid_d = (state_q == S_T3);
    rsp_err_d   = (state_q == S_T3) && err_q;
    rdata_d     = ((state_q == S_T3) && !write_q) ? D_in : rdata_q;
  end

  // State, latched command and registered bus/response outputs
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
      write_q     <= 1'b0;
      io_q        <= 1'b0;
      alive_q     <= 1'b0;
      addr_q      <= 16'h0000;
      dout_q      <= 8'h00;
      doe_q       <= 1'b0;
      nmreq_q     <= 1'b1;
      niorq_q     <= 1'b1;
      nrd_q       <= 1'b1;
      nwr_q       <= 1'b1;
      nbusack_q   <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rdata_q     <= 8'h00;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      err_q       <= err_d;
      write_q     <= write_d;
      io_q        <= io_d;
      alive_q     <= 1'b1;
      addr_q      <= addr_d;
      dout_q      <= dout_d;
      doe_q       <= doe_d;
      nmreq_q     <= nmreq_d;
      niorq_q     <= niorq_d;
      nrd_q       <= nrd_d;
      nwr_q       <= nwr_d;
      nbusack_q   <= nbusack_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rdata_q     <= rdata_d;
    end
  end

endmodule

// File: tb/tb_z80_bus_master.sv
// tb/tb_z80_bus_master.sv - self-checking bench for z80_bus_master
module tb_z80_bus_master;

  localparam int MAXW = 4;

  typedef enum int {P_IDLE, P_T1, P_T2, P_TA, P_TW, P_T3} phase_e;

  logic        CLK = 1'b0;
  logic        nRESET = 1'b1;
  logic        cmd_valid, cmd_ready, cmd_write, cmd_io;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid, rsp_err;
  logic [7:0]  rsp_rdata;
  logic [15:0] A;
  logic [7:0]  D_out, D_in;
  logic        D_oe, nMREQ, nIORQ, nRD, nWR, nWAIT, nBUSRQ, nBUSACK;

  int errors = 0;
  int checks = 0;
  logic [7:0] model_rdata;

  z80_bus_master #(.MAX_WAIT(MAXW)) dut (
    .CLK(CLK), .nRESET(nRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_io(cmd_io),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .A(A), .D_out(D_out), .D_oe(D_oe), .D_in(D_in),
    .nMREQ(nMREQ), .nIORQ(nIORQ), .nRD(nRD), .nWR(nWR),
    .nWAIT(nWAIT), .nBUSRQ(nBUSRQ), .nBUSACK(nBUSACK)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish got timeout want finish");
    $fatal(1);
  end

  // One bus transaction checked cycle by cycle against the expected phase sequence.
  // lows = number of consecutive nWAIT-low samples the responder gives; the master
  // tolerates MAXW wait states and flags an error once that many have been counted.
  task automatic run_cmd(input string tag, input bit wr, input bit io, input logic [15:0] addr,
                         input logic [7:0] wd, input int lows, input logic [7:0] rd,
                         input int busrq_c, output int waited);
    int ntw, n, first;
    bit exp_err, act, late;
    phase_e p;
    logic [15:0] got_v, exp_v;
    logic [7:0] exp_rd;
    ntw     = (lows < MAXW) ? lows : MAXW;
    exp_err = (lows >= MAXW);
    first   = io ? 3 : 2;
    n       = first + ntw + 1;
    waited  = 0;
    while (cmd_ready !== 1'b1 && waited < 40) begin
      @(negedge CLK);
      waited++;
    end
    if (cmd_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL %s cmd_ready timeout got %b want 1", tag, cmd_ready);
      return;
    end
    cmd_valid = 1'b1; cmd_write = wr; cmd_io = io; cmd_addr = addr; cmd_wdata = wd;
    nWAIT = 1'($urandom); D_in = 8'($urandom);
    @(negedge CLK);
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_io = 1'($urandom);
    cmd_addr = 16'($urandom); cmd_wdata = 8'($urandom);
    for (int c = 1; c <= n + 1; c++) begin
      if (c == n + 1)          p = P_IDLE;
      else if (c == n)         p = P_T3;
      else if (c == 1)         p = P_T1;
      else if (c == 2)         p = P_T2;
      else if (io && c == 3)   p = P_TA;
      else                     p = P_TW;
      act  = (p != P_IDLE);
      late = act && (p != P_T1);
      exp_v = {8'h00, !(act && !io), !(late && io), !(!wr && (io ? late : act)),
               !(wr && late), wr && act, 1'b1, (c == n + 1), 1'b0};
      got_v = {8'h00, nMREQ, nIORQ, nRD, nWR, D_oe, nBUSACK, rsp_valid, 1'b0};
      checks++;
      if (got_v !== exp_v || A !== addr) begin
        errors++;
        $display("FAIL %s bus cycle=%0d phase=%0d got strobes(mreq,iorq,rd,wr,oe,back,vld)=%b A=%h want %b A=%h",
                 tag, c, p, got_v[7:1], A, exp_v[7:1], addr);
      end
      if (wr && act) begin
        checks++;
        if (D_out !== wd) begin
          errors++;
          $display("FAIL %s dout cycle=%0d got %h want %h", tag, c, D_out, wd);
        end
      end
      if (c == n + 1) begin
        exp_rd = wr ? model_rdata : rd;
        model_rdata = exp_rd;
        checks++;
        if (rsp_rdata !== exp_rd || rsp_err !== exp_err) begin
          errors++;
          $display("FAIL %s rsp got rdata=%h err=%b want rdata=%h err=%b",
                   tag, rsp_rdata, rsp_err, exp_rd, exp_err);
        end
      end else begin
        if (c < first)                 nWAIT = 1'($urandom);
        else if (c < first + lows)     nWAIT = 1'b0;
        else                           nWAIT = 1'b1;
        D_in = (c == n) ? rd : 8'($urandom);
        if (c == busrq_c) nBUSRQ = 1'b0;
        @(negedge CLK);
      end
    end
  endtask

  task automatic test_reset();
    nRESET = 1'b1;
    #2 nRESET = 1'b0;
    #1;
    checks++;
    if ({nMREQ, nIORQ, nRD, nWR, D_oe, nBUSACK, cmd_ready, rsp_valid, rsp_err} !== 9'b1111_0100_0
        || A !== 16'h0000 || rsp_rdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_state got ctl=%b A=%h rdata=%h want ctl=111101000 A=0000 rdata=00",
               {nMREQ, nIORQ, nRD, nWR, D_oe, nBUSACK, cmd_ready, rsp_valid, rsp_err}, A, rsp_rdata);
    end
    repeat (3) @(negedge CLK);
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_held got %b want 0", cmd_ready);
    end
    nRESET = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_before_edge got %b want 0", cmd_ready);
    end
    @(negedge CLK);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_first_edge got %b want 1", cmd_ready);
    end
    model_rdata = 8'h00;
  endtask

  task automatic test_mem_read();
    int w;
    run_cmd("mem_read", 1'b0, 1'b0, 16'h1234, 8'h00, 0, 8'hA5, 0, w);
    @(negedge CLK);
  endtask

  task automatic test_io_write();
    int w;
    run_cmd("io_write", 1'b1, 1'b1, 16'h0055, 8'h3C, 2, 8'h00, 0, w);
    @(negedge CLK);
  endtask

  task automatic test_timeout();
    int w;
    run_cmd("timeout", 1'b0, 1'b0, 16'h8001, 8'h00, 20, 8'h5A, 0, w);
    @(negedge CLK);
    run_cmd("timeout_io", 1'b1, 1'b1, 16'h00F0, 8'h99, 9, 8'h00, 0, w);
    @(negedge CLK);
  endtask

  task automatic test_busreq();
    int w;
    bit ok;
    run_cmd("busreq_read", 1'b0, 1'b0, 16'hC0DE, 8'h00, 1, 8'h6E, 2, w);
    @(negedge CLK);
    checks++;
    if (nBUSACK !== 1'b0 || cmd_ready !== 1'b0 || {nMREQ, nIORQ, nRD, nWR} !== 4'hF || D_oe !== 1'b0) begin
      errors++;
      $display("FAIL busrel_enter got back=%b rdy=%b strobes=%b oe=%b want 0 0 1111 0",
               nBUSACK, cmd_ready, {nMREQ, nIORQ, nRD, nWR}, D_oe);
    end
    repeat (3) @(negedge CLK);
    checks++;
    if (nBUSACK !== 1'b0) begin
      errors++;
      $display("FAIL busrel_hold got %b want 0", nBUSACK);
    end
    nBUSRQ = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 2 && !ok; i++) begin
      @(negedge CLK);
      ok = (nBUSACK === 1'b1 && cmd_ready === 1'b1);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL busrel_exit got back=%b rdy=%b want 1 1", nBUSACK, cmd_ready);
    end
    // bus request wins over a command offered in the same idle cycle
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_io = 1'b0; cmd_addr = 16'h7777; nBUSRQ = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL busrq_pref_ready got %b want 0", cmd_ready);
    end
    repeat (3) begin
      @(negedge CLK);
      checks++;
      if (nBUSACK !== 1'b0 || nMREQ !== 1'b1 || nRD !== 1'b1) begin
        errors++;
        $display("FAIL busrq_pref got back=%b mreq=%b rd=%b want 0 1 1", nBUSACK, nMREQ, nRD);
      end
    end
    cmd_valid = 1'b0;
    nBUSRQ = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_reset_mid();
    int g;
    g = 0;
    while (cmd_ready !== 1'b1 && g < 40) begin
      @(negedge CLK);
      g++;
    end
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_io = 1'b0; cmd_addr = 16'hBEEF; cmd_wdata = 8'h77;
    nWAIT = 1'b0;
    @(negedge CLK);
    cmd_valid = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if (nWR !== 1'b0 || D_oe !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_in_tw got wr=%b oe=%b want 0 1", nWR, D_oe);
    end
    #2 nRESET = 1'b0;
    #1;
    checks++;
    if ({nMREQ, nIORQ, nRD, nWR, D_oe, nBUSACK, rsp_valid} !== 7'b1111_010 || A !== 16'h0000) begin
      errors++;
      $display("FAIL mid_reset_async got ctl=%b A=%h want 1111010 A=0000",
               {nMREQ, nIORQ, nRD, nWR, D_oe, nBUSACK, rsp_valid}, A);
    end
    repeat (2) begin
      @(negedge CLK);
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_no_rsp got %b want 0", rsp_valid);
      end
    end
    nRESET = 1'b1;
    nWAIT = 1'b1;
    model_rdata = 8'h00;
    @(negedge CLK);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_release_rsp got %b want 0", rsp_valid);
    end
    run_cmd("after_reset", 1'b0, 1'b0, 16'h4321, 8'h00, 1, 8'hD2, 0, g);
    @(negedge CLK);
  endtask

  task automatic test_back_to_back();
    int w;
    run_cmd("b2b_first", 1'b0, 1'b0, 16'h1000, 8'h00, 0, 8'h11, 0, w);
    run_cmd("b2b_second", 1'b0, 1'b0, 16'h2000, 8'h00, 0, 8'h22, 0, w);
    checks++;
    if (w !== 0) begin
      errors++;
      $display("FAIL b2b_gap got %0d idle cycles want 0", w);
    end
    run_cmd("b2b_io_wr", 1'b1, 1'b1, 16'h00AA, 8'hE1, 1, 8'h00, 0, w);
    checks++;
    if (w !== 0) begin
      errors++;
      $display("FAIL b2b_gap2 got %0d idle cycles want 0", w);
    end
    @(negedge CLK);
  endtask

  task automatic test_random();
    int w;
    for (int i = 0; i < 24; i++) begin
      run_cmd("random", 1'($urandom), 1'($urandom), 16'($urandom), 8'($urandom),
              $urandom_range(6, 0), 8'($urandom), 0, w);
      repeat ($urandom_range(2, 0)) @(negedge CLK);
    end
    @(negedge CLK);
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_io = 1'b0; cmd_addr = 16'h0000; cmd_wdata = 8'h00;
    D_in = 8'h00; nWAIT = 1'b1; nBUSRQ = 1'b1;
    model_rdata = 8'h00;
    test_reset();
    test_mem_read();
    test_io_write();
    test_timeout();
    test_busreq();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
